// File: rtl/nap_arb_pkg.sv
// -----------------------------------------------------------------------------
// nap_arb_pkg
// Shared types and helpers for the NAP transmit-stream arbiter.
//   t_arb_state : arbiter FSM state (idle arbitration / locked to one packet)
//   COUNT_WIDTH : width of each per-requester packet counter (stats build)
//   MAX_REQ     : largest supported requester count
//   rr_pick()   : round-robin winner search starting at a pointer
// -----------------------------------------------------------------------------
package nap_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } t_arb_state;

   localparam int COUNT_WIDTH = 16;
   localparam int MAX_REQ     = 8;

   // Returns the first set bit of cand at or after ptr, wrapping modulo num.
   // Returns 0 when cand is empty; callers only use the result when |cand.
   function automatic logic [2:0] rr_pick(input logic [7:0] cand,
                                          input logic [2:0] ptr,
                                          input int         num);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = 3'd0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % num;
         if ((k < num) && !found && cand[idx[2:0]]) begin
            pick  = idx[2:0];
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/nap_ds_out_reg.sv
// -----------------------------------------------------------------------------
// nap_ds_out_reg
// Single-entry ready/valid register feeding the NAP transmit interface.
// A loaded beat is held untouched while the NAP stalls; the entry empties
// when the NAP takes it and nothing new is loaded in the same cycle.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_load               load a new beat (caller guarantees slot is free)
//   i_sop/i_eop/i_addr/i_data  beat payload to load
//   i_tx_ready           NAP ready
//   o_tx_valid/sop/eop/addr/data  registered NAP outputs
// -----------------------------------------------------------------------------
module nap_ds_out_reg #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_load,
   input  logic                  i_sop,
   input  logic                  i_eop,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_tx_ready,
   output logic                  o_tx_valid,
   output logic                  o_tx_sop,
   output logic                  o_tx_eop,
   output logic [ADDR_WIDTH-1:0] o_tx_addr,
   output logic [DATA_WIDTH-1:0] o_tx_data
);

   logic                  r_valid;
   logic                  r_sop;
   logic                  r_eop;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;

   // Output entry: load, drain, or hold while stalled.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_sop   <= i_sop;
         r_eop   <= i_eop;
         r_addr  <= i_addr;
         r_data  <= i_data;
      end else if (i_tx_ready) begin
         // Drained with no replacement; payload is left as-is.
         r_valid <= 1'b0;
      end
   end

   assign o_tx_valid = r_valid;
   assign o_tx_sop   = r_sop;
   assign o_tx_eop   = r_eop;
   assign o_tx_addr  = r_addr;
   assign o_tx_data  = r_data;

endmodule

// File: rtl/nap_ds_tx_arbiter.sv
// -----------------------------------------------------------------------------
// nap_ds_tx_arbiter
// Packet-aware round-robin arbiter sharing one NAP transmit data stream
// between NUM_REQ requesters. A grant is taken on a sop beat and held until
// that requester's eop beat is accepted, so packets never interleave.
// Optional build macro: NAP_ARB_STATS_EN adds o_pkt_count (per-requester
// count of accepted eop beats, COUNT_WIDTH bits each, wrapping).
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_req_valid/sop/eop            per-requester beat qualifiers
//   i_req_addr, i_req_data         per-requester destination and payload
//   o_req_ready                    per-requester ready (one-hot or zero)
//   o_tx_valid/sop/eop/addr/data   registered NAP transmit outputs
//   i_tx_ready                     NAP ready
//   o_grant                        current one-hot grant, zero when idle
//   o_err_nosop                    sticky: valid without sop seen while idle
//   o_pkt_count                    (NAP_ARB_STATS_EN only) packet counters
// -----------------------------------------------------------------------------
module nap_ds_tx_arbiter
   import nap_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ-1:0]            i_req_sop,
   input  logic [NUM_REQ-1:0]            i_req_eop,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_tx_valid,
   output logic                          o_tx_sop,
   output logic                          o_tx_eop,
   output logic [ADDR_WIDTH-1:0]         o_tx_addr,
   output logic [DATA_WIDTH-1:0]         o_tx_data,
   input  logic                          i_tx_ready,
   output logic [NUM_REQ-1:0]            o_grant,
`ifdef NAP_ARB_STATS_EN
   output logic [NUM_REQ*COUNT_WIDTH-1:0] o_pkt_count,
`endif
   output logic                          o_err_nosop
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

   t_arb_state            r_state;
   t_arb_state            w_state_nxt;
   logic [NUM_REQ-1:0]    r_grant;
   logic [2:0]            r_gidx;
   logic [2:0]            r_ptr;
   logic                  r_err_nosop;

   logic [NUM_REQ-1:0]    w_cand;
   logic [7:0]            w_cand8;
   logic [2:0]            w_pick;
   logic [NUM_REQ-1:0]    w_pick_onehot;
   logic [2:0]            w_ptr_nxt;
   logic                  w_nosop_seen;

   logic                  w_out_ready;
   logic [NUM_REQ-1:0]    w_req_ready;
   logic                  w_accept;
   logic                  w_release;

   logic                  w_sel_sop;
   logic                  w_sel_eop;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_data;

   // ---------------------------------------------------------------------
   // Arbitration helpers
   // ---------------------------------------------------------------------
   assign w_cand = i_req_valid & i_req_sop;

   // Widen the candidate set to the fixed width rr_pick() expects.
   always_comb begin
      w_cand8                = 8'd0;
      w_cand8[NUM_REQ-1:0]   = w_cand;
   end

   assign w_pick = rr_pick(w_cand8, r_ptr, NUM_REQ);

   // Decode the round-robin winner into a one-hot grant vector.
   always_comb begin
      w_pick_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_pick_onehot[i] = (w_pick == 3'(i));
      end
   end

   assign w_ptr_nxt = (r_gidx == LAST_IDX) ? 3'd0 : (r_gidx + 3'd1);

   // A beat without sop while idle cannot start a packet: protocol error.
   assign w_nosop_seen = (r_state == ARB_IDLE) && |(i_req_valid & ~i_req_sop);

   // AND-OR mux of the granted requester's beat (grant is one-hot or zero).
   always_comb begin
      w_sel_sop  = 1'b0;
      w_sel_eop  = 1'b0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel_sop  = w_sel_sop  | (i_req_sop[i] & r_grant[i]);
         w_sel_eop  = w_sel_eop  | (i_req_eop[i] & r_grant[i]);
         w_sel_addr = w_sel_addr |
                      (i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_grant[i]}});
         w_sel_data = w_sel_data |
                      (i_req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: lock on a winner, release on the accepted eop beat.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (|w_cand) begin
               w_state_nxt = ARB_LOCKED;
            end else begin
               w_state_nxt = ARB_IDLE;
            end
         end
         ARB_LOCKED: begin
            if (w_release) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               w_state_nxt = ARB_LOCKED;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // FSM outputs: ready back-pressure and beat acceptance.
   always_comb begin
      // The output slot is free if empty or being drained this cycle.
      w_out_ready = i_tx_ready | ~o_tx_valid;
      w_req_ready = r_grant & {NUM_REQ{w_out_ready}};
      w_accept    = |(i_req_valid & w_req_ready);
      w_release   = w_accept & w_sel_eop;
   end

   assign o_req_ready = w_req_ready;

   // Grant, granted index and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_grant <= '0;
         r_gidx  <= 3'd0;
         r_ptr   <= 3'd0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (|w_cand) begin
                  r_grant <= w_pick_onehot;
                  r_gidx  <= w_pick;
               end
            end
            ARB_LOCKED: begin
               if (w_release) begin
                  r_grant <= '0;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            default: begin
               r_grant <= '0;
            end
         endcase
      end
   end

   assign o_grant = r_grant;

   // Sticky no-sop error flag, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_err_nosop <= 1'b0;
      end else if (w_nosop_seen) begin
         r_err_nosop <= 1'b1;
      end
   end

   assign o_err_nosop = r_err_nosop;

   // ---------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------
   nap_ds_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_out_reg (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_accept),
      .i_sop      (w_sel_sop),
      .i_eop      (w_sel_eop),
      .i_addr     (w_sel_addr),
      .i_data     (w_sel_data),
      .i_tx_ready (i_tx_ready),
      .o_tx_valid (o_tx_valid),
      .o_tx_sop   (o_tx_sop),
      .o_tx_eop   (o_tx_eop),
      .o_tx_addr  (o_tx_addr),
      .o_tx_data  (o_tx_data)
   );

`ifdef NAP_ARB_STATS_EN
   logic [NUM_REQ*COUNT_WIDTH-1:0] r_pkt_count;

   // Per-requester packet counters, bumped on each accepted eop beat.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pkt_count <= '0;
      end else if (w_release) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
               r_pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] <=
                  r_pkt_count[i*COUNT_WIDTH +: COUNT_WIDTH] +
                  {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign o_pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_nap_ds_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nap_ds_tx_arbiter
// Directed bench for nap_ds_tx_arbiter (NUM_REQ=4, DATA_WIDTH=256,
// ADDR_WIDTH=4). Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nap_ds_tx_arbiter;
   import nap_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 256;
   localparam int AW = 4;

   logic             i_clk;
   logic             i_reset;
   logic [NR-1:0]    i_req_valid;
   logic [NR-1:0]    i_req_sop;
   logic [NR-1:0]    i_req_eop;
   logic [NR*AW-1:0] i_req_addr;
   logic [NR*DW-1:0] i_req_data;
   logic [NR-1:0]    o_req_ready;
   logic             o_tx_valid;
   logic             o_tx_sop;
   logic             o_tx_eop;
   logic [AW-1:0]    o_tx_addr;
   logic [DW-1:0]    o_tx_data;
   logic             i_tx_ready;
   logic [NR-1:0]    o_grant;
   logic             o_err_nosop;
`ifdef NAP_ARB_STATS_EN
   logic [NR*COUNT_WIDTH-1:0] o_pkt_count;
`endif

   int checks = 0;
   int errors = 0;

   nap_ds_tx_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_req_valid (i_req_valid),
      .i_req_sop   (i_req_sop),
      .i_req_eop   (i_req_eop),
      .i_req_addr  (i_req_addr),
      .i_req_data  (i_req_data),
      .o_req_ready (o_req_ready),
      .o_tx_valid  (o_tx_valid),
      .o_tx_sop    (o_tx_sop),
      .o_tx_eop    (o_tx_eop),
      .o_tx_addr   (o_tx_addr),
      .o_tx_data   (o_tx_data),
      .i_tx_ready  (i_tx_ready),
      .o_grant     (o_grant),
`ifdef NAP_ARB_STATS_EN
      .o_pkt_count (o_pkt_count),
`endif
      .o_err_nosop (o_err_nosop)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic s, input logic e,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      i_req_valid[r]          = v;
      i_req_sop[r]            = s;
      i_req_eop[r]            = e;
      i_req_addr[r*AW +: AW]  = a;
      i_req_data[r*DW +: DW]  = d;
   endtask

   task automatic clear_req(input int r);
      set_req(r, 1'b0, 1'b0, 1'b0, 4'h0, 256'h0);
   endtask

   // Two clocks of reset; returns on the falling edge where reset drops.
   task automatic do_reset();
      i_reset = 1'b1;
      for (int r = 0; r < NR; r++) clear_req(r);
      i_tx_ready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   int             win   [5];
   logic [DW-1:0]  wdata [5];
   logic [NR-1:0]  exp_g;

   initial begin
      i_reset     = 1'b1;
      i_req_valid = '0;
      i_req_sop   = '0;
      i_req_eop   = '0;
      i_req_addr  = '0;
      i_req_data  = '0;
      i_tx_ready  = 1'b1;
      repeat (3) @(negedge i_clk);

      // ---- reset state ----
      chk("rst_tx_valid", 256'(o_tx_valid), 256'h0);
      chk("rst_grant",    256'(o_grant),    256'h0);
      chk("rst_ready",    256'(o_req_ready),256'h0);
      chk("rst_err",      256'(o_err_nosop),256'h0);
      chk("rst_tx_data",  256'(o_tx_data),  256'h0);
      i_reset = 1'b0;

      // ---- 1) req0 three-beat packet, NAP always ready ----
      set_req(0, 1'b1, 1'b1, 1'b0, 4'h5, 256'h1001);
      @(negedge i_clk);
      chk("t1_grant",    256'(o_grant),     256'h1);
      chk("t1_ready",    256'(o_req_ready), 256'h1);
      chk("t1_novalid",  256'(o_tx_valid),  256'h0);
      @(negedge i_clk);
      chk("t1_b0_valid", 256'(o_tx_valid),  256'h1);
      chk("t1_b0_sop",   256'(o_tx_sop),    256'h1);
      chk("t1_b0_eop",   256'(o_tx_eop),    256'h0);
      chk("t1_b0_addr",  256'(o_tx_addr),   256'h5);
      chk("t1_b0_data",  o_tx_data,         256'h1001);
      set_req(0, 1'b1, 1'b0, 1'b0, 4'h5, 256'h1002);
      @(negedge i_clk);
      chk("t1_b1_data",  o_tx_data,         256'h1002);
      chk("t1_b1_sop",   256'(o_tx_sop),    256'h0);
      set_req(0, 1'b1, 1'b0, 1'b1, 4'h6, 256'h1003);
      @(negedge i_clk);
      chk("t1_b2_data",  o_tx_data,         256'h1003);
      chk("t1_b2_eop",   256'(o_tx_eop),    256'h1);
      chk("t1_b2_addr",  256'(o_tx_addr),   256'h6);
      chk("t1_released", 256'(o_grant),     256'h0);
      clear_req(0);
      @(negedge i_clk);
      chk("t1_drained",  256'(o_tx_valid),  256'h0);

      // ---- 2) four simultaneous single-beat packets, pointer wraps ----
      do_reset();
      win   = '{0, 1, 2, 3, 0};
      wdata = '{256'h200, 256'h201, 256'h202, 256'h203, 256'h210};
      for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b1, 1'b1, 4'(r), 256'h200 + 256'(r));
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         exp_g = 4'b0001 << win[k];
         chk($sformatf("t2_grant%0d", k), 256'(o_grant), 256'(exp_g));
         @(negedge i_clk);
         chk($sformatf("t2_data%0d", k), o_tx_data, wdata[k]);
         chk($sformatf("t2_sopeop%0d", k), 256'({o_tx_sop, o_tx_eop}), 256'h3);
         chk($sformatf("t2_idle%0d", k), 256'(o_grant), 256'h0);
         clear_req(win[k]);
         if (k == 1) set_req(0, 1'b1, 1'b1, 1'b1, 4'h0, 256'h210);
      end
      @(negedge i_clk);
      chk("t2_drained", 256'(o_tx_valid), 256'h0);

      // ---- 3) req1 four-beat packet with a 5-cycle NAP stall ----
      do_reset();
      set_req(1, 1'b1, 1'b1, 1'b0, 4'h1, 256'h301);
      @(negedge i_clk);
      chk("t3_grant", 256'(o_grant), 256'h2);
      @(negedge i_clk);
      chk("t3_b0_data", o_tx_data, 256'h301);
      set_req(1, 1'b1, 1'b0, 1'b0, 4'h1, 256'h302);
      @(negedge i_clk);
      chk("t3_b1_data", o_tx_data, 256'h302);
      // Beat 3 carries a stray sop; it must pass through unchanged.
      set_req(1, 1'b1, 1'b1, 1'b0, 4'h1, 256'h303);
      i_tx_ready = 1'b0;
      #1;
      chk("t3_stall_ready", 256'(o_req_ready), 256'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         chk($sformatf("t3_frozen_data%0d", c), o_tx_data, 256'h302);
         chk($sformatf("t3_frozen_valid%0d", c), 256'(o_tx_valid), 256'h1);
         chk($sformatf("t3_frozen_ready%0d", c), 256'(o_req_ready), 256'h0);
      end
      @(negedge i_clk);
      chk("t3_frozen_last", o_tx_data, 256'h302);
      i_tx_ready = 1'b1;
      #1;
      chk("t3_resume_ready", 256'(o_req_ready), 256'h2);
      @(negedge i_clk);
      chk("t3_b2_data", o_tx_data, 256'h303);
      chk("t3_b2_sop", 256'(o_tx_sop), 256'h1);
      set_req(1, 1'b1, 1'b0, 1'b1, 4'h1, 256'h304);
      @(negedge i_clk);
      chk("t3_b3_data", o_tx_data, 256'h304);
      chk("t3_b3_eop", 256'(o_tx_eop), 256'h1);
      chk("t3_released", 256'(o_grant), 256'h0);
      clear_req(1);

      // ---- 4) req2 valid without sop while idle ----
      do_reset();
      set_req(2, 1'b1, 1'b0, 1'b0, 4'h2, 256'h400);
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         chk($sformatf("t4_err%0d", c), 256'(o_err_nosop), 256'h1);
         chk($sformatf("t4_grant%0d", c), 256'(o_grant), 256'h0);
         chk($sformatf("t4_ready%0d", c), 256'(o_req_ready), 256'h0);
         chk($sformatf("t4_txv%0d", c), 256'(o_tx_valid), 256'h0);
      end
      clear_req(2);
      @(negedge i_clk);
      chk("t4_sticky", 256'(o_err_nosop), 256'h1);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("t4_cleared", 256'(o_err_nosop), 256'h0);
      i_reset = 1'b0;

      // ---- 5) reset mid-packet of req3 restores pointer to 0 ----
      set_req(2, 1'b1, 1'b1, 1'b1, 4'h2, 256'h500);
      @(negedge i_clk);
      chk("t5_grant2", 256'(o_grant), 256'h4);
      @(negedge i_clk);
      clear_req(2);
      set_req(3, 1'b1, 1'b1, 1'b0, 4'h3, 256'h531);
      @(negedge i_clk);
      chk("t5_grant3", 256'(o_grant), 256'h8);
      @(negedge i_clk);
      chk("t5_b0_data", o_tx_data, 256'h531);
      set_req(3, 1'b1, 1'b1, 1'b0, 4'h3, 256'h532);
      set_req(0, 1'b1, 1'b1, 1'b0, 4'h0, 256'h501);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("t5_rst_txv",   256'(o_tx_valid),  256'h0);
      chk("t5_rst_sop",   256'(o_tx_sop),    256'h0);
      chk("t5_rst_eop",   256'(o_tx_eop),    256'h0);
      chk("t5_rst_addr",  256'(o_tx_addr),   256'h0);
      chk("t5_rst_data",  o_tx_data,         256'h0);
      chk("t5_rst_grant", 256'(o_grant),     256'h0);
      chk("t5_rst_ready", 256'(o_req_ready), 256'h0);
      chk("t5_rst_err",   256'(o_err_nosop), 256'h0);
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("t5_req0_wins", 256'(o_grant), 256'h1);

`ifdef NAP_ARB_STATS_EN
      // ---- 6) packet counters (three packets from req0) ----
      do_reset();
      for (int p = 0; p < 3; p++) begin
         set_req(0, 1'b1, 1'b1, 1'b1, 4'h0, 256'h600 + 256'(p));
         @(negedge i_clk);
         @(negedge i_clk);
         clear_req(0);
      end
      @(negedge i_clk);
      chk("t6_cnt0",    256'(o_pkt_count[15:0]),  256'h3);
      chk("t6_cnt_oth", 256'(o_pkt_count[63:16]), 256'h0);
`endif

      for (int r = 0; r < NR; r++) clear_req(r);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
